// File: rtl/window_5x5_gen_if.sv
// window_5x5_gen_if: pixel stream in, 25-value window out; out_eol exists only with WIN_EOL_EN
interface window_5x5_gen_if #(parameter int DSIZE = 64);
  logic in_valid;
  logic in_sof;
  logic [DSIZE-1:0] in_data;
  logic out_valid;
  logic [DSIZE-1:0] od [25];
`ifdef WIN_EOL_EN
  logic out_eol;
  modport master(output in_valid, in_sof, in_data, input out_valid, od, out_eol);
  modport slave(input in_valid, in_sof, in_data, output out_valid, od, out_eol);
`else
  modport master(output in_valid, in_sof, in_data, input out_valid, od);
  modport slave(input in_valid, in_sof, in_data, output out_valid, od);
`endif
endinterface

// File: rtl/window_5x5_gen.sv
// window_5x5_gen: raster stream to 5x5 window via four line buffers; WIN_EOL_EN adds out_eol
module window_5x5_gen #(
  parameter int DSIZE = 64,
  parameter int IMG_W = 640,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic rst_n,
  window_5x5_gen_if.slave s
);
  localparam int AW = $clog2(IMG_W);
  logic [CNT_W-1:0] col, pcol;
  logic [2:0] row, prow;
  logic [DSIZE-1:0] lb [4][IMG_W];
  logic [DSIZE-1:0] lb_out [4];
  logic [DSIZE-1:0] nc [5];
  logic [DSIZE-1:0] win [5][5];
  logic last;
  // in_sof forces the current pixel to frame position (0,0), even mid-line
  always_comb begin
    pcol = s.in_sof ? '0 : col;
    prow = s.in_sof ? '0 : row;
    last = pcol == CNT_W'(IMG_W - 1);
    lb_out[0] = lb[0][pcol[AW-1:0]];
    lb_out[1] = lb[1][pcol[AW-1:0]];
    lb_out[2] = lb[2][pcol[AW-1:0]];
    lb_out[3] = lb[3][pcol[AW-1:0]];
    nc[4] = s.in_data;
    nc[3] = lb_out[0];
    nc[2] = lb_out[1];
    nc[1] = lb_out[2];
    nc[0] = lb_out[3];
  end
  always_ff @(posedge clock) begin
    if (s.in_valid) begin
      lb[0][pcol[AW-1:0]] <= s.in_data;
      lb[1][pcol[AW-1:0]] <= lb_out[0];
      lb[2][pcol[AW-1:0]] <= lb_out[1];
      lb[3][pcol[AW-1:0]] <= lb_out[2];
    end
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      s.out_valid <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else begin
      s.out_valid <= s.in_valid && prow >= 3'd4 && pcol >= CNT_W'(4);
      if (s.in_valid) begin
        col <= last ? '0 : pcol + CNT_W'(1);
        row <= last && prow != 3'd4 ? prow + 3'd1 : prow;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++)
            win[r][c] <= win[r][c+1];
          win[r][4] <= nc[r];
        end
      end
    end
  end
`ifdef WIN_EOL_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) s.out_eol <= 1'b0;
    else s.out_eol <= s.in_valid && prow >= 3'd4 && last;
  end
`endif
  for (genvar r = 0; r < 5; r++) begin : g_r
    for (genvar c = 0; c < 5; c++) begin : g_c
      assign s.od[5*r+c] = win[r][c];
    end
  end
endmodule

// File: tb/tb_window_5x5_gen.sv
// tb_window_5x5_gen: frame-indexed image model vs DUT windows, directed scenarios plus random stream
module tb_window_5x5_gen;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int errs = 0;
  window_5x5_gen_if #(.DSIZE(16)) ifc();
  window_5x5_gen #(.DSIZE(16), .IMG_W(8), .CNT_W(4)) dut(.clock(clock), .rst_n(rst_n), .s(ifc));
  always #5 clock = ~clock;

  logic [15:0] img [256][8];
  int m_r, m_c;
  logic e_v, e_eol;
  logic [15:0] e_od [25];
  logic [15:0] cap0[$], cap12[$], cap24[$], ref0[$], ref12[$], ref24[$];
  logic capeol[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // model: store each accepted pixel at its frame position, window = image rows R-4..R, cols C-4..C
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_r = 0; m_c = 0; e_v = 0; e_eol = 0;
    end else begin
      e_v = 0; e_eol = 0;
      if (ifc.in_valid) begin
        if (ifc.in_sof) begin m_r = 0; m_c = 0; end
        img[m_r][m_c] = ifc.in_data;
        if (m_r >= 4 && m_c >= 4) begin
          e_v = 1;
          e_eol = (m_c == 7);
          for (int i = 0; i < 25; i++) e_od[i] = img[m_r - 4 + i / 5][m_c - 4 + i % 5];
        end
        m_c++;
        if (m_c == 8) begin m_c = 0; m_r++; end
      end
    end
  end

  always @(negedge clock) begin
    chk("out_valid", {63'd0, ifc.out_valid}, {63'd0, e_v});
    if (e_v) for (int i = 0; i < 25; i++) chk($sformatf("od%0d", i), 64'(ifc.od[i]), 64'(e_od[i]));
`ifdef WIN_EOL_EN
    chk("out_eol", {63'd0, ifc.out_eol}, {63'd0, e_eol});
`endif
    if (ifc.out_valid) begin
      cap0.push_back(ifc.od[0]);
      cap12.push_back(ifc.od[12]);
      cap24.push_back(ifc.od[24]);
`ifdef WIN_EOL_EN
      capeol.push_back(ifc.out_eol);
`else
      capeol.push_back(1'b0);
`endif
    end
  end

  task automatic px(input logic v, input logic sf, input logic [15:0] d);
    ifc.in_valid = v; ifc.in_sof = sf; ifc.in_data = d;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'b0, 1'b0, 16'(i));
  endtask

  task automatic frame(input int rows, input int tail, input int base, input bit tog);
    for (int r = 0; r <= rows; r++)
      for (int c = 0; c < (r == rows ? tail : 8); c++) begin
        px(1'b1, r == 0 && c == 0, 16'(base + r * 16 + c));
        if (tog) px(1'b0, 1'b0, 16'($urandom));
      end
  endtask

  task automatic clr();
    cap0 = {}; cap12 = {}; cap24 = {}; capeol = {};
  endtask

  task automatic cmp_ref(input string n);
    chk({n, "_count"}, 64'(cap0.size()), 64'(ref0.size()));
    if (cap0.size() == ref0.size())
      for (int i = 0; i < ref0.size(); i++) begin
        chk({n, "_od00"}, 64'(cap0[i]), 64'(ref0[i]));
        chk({n, "_od12"}, 64'(cap12[i]), 64'(ref12[i]));
        chk({n, "_od24"}, 64'(cap24[i]), 64'(ref24[i]));
      end
  endtask

  initial begin
    ifc.in_valid = 0; ifc.in_sof = 0; ifc.in_data = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    for (int i = 0; i < 25; i++) chk("rst_od", 64'(ifc.od[i]), 64'd0);
    rst_n = 1;
    @(posedge clock); #1;

    clr(); frame(6, 0, 0, 0); idle(3);
    chk("s1_count", 64'(cap0.size()), 64'd8);
    if (cap0.size() == 8) begin
      chk("s1_first_od00", 64'(cap0[0]), 64'h0000);
      chk("s1_first_od12", 64'(cap12[0]), 64'h0022);
      chk("s1_first_od24", 64'(cap24[0]), 64'h0044);
      chk("s3_row5_od00", 64'(cap0[4]), 64'h0010);
      chk("s3_row5_od24", 64'(cap24[4]), 64'h0054);
`ifdef WIN_EOL_EN
      chk("eol_w0", {63'd0, capeol[0]}, 64'd0);
      chk("eol_w3", {63'd0, capeol[3]}, 64'd1);
      chk("eol_w4", {63'd0, capeol[4]}, 64'd0);
      chk("eol_w7", {63'd0, capeol[7]}, 64'd1);
`endif
    end
    ref0 = cap0; ref12 = cap12; ref24 = cap24;

    clr(); frame(6, 0, 0, 1); idle(3);
    cmp_ref("s2_toggle");

    clr(); frame(5, 2, 0, 0); frame(5, 0, 'h100, 0); idle(3);
    chk("s4_count", 64'(cap0.size()), 64'd8);
    if (cap0.size() == 8) begin
      chk("s4_restart_od00", 64'(cap0[4]), 64'h0100);
      chk("s4_restart_od24", 64'(cap24[4]), 64'h0144);
    end

    clr(); frame(5, 6, 0, 0);
    chk("s5_pre_rst_valid", {63'd0, ifc.out_valid}, 64'd1);
    rst_n = 0;
    #1;
    chk("s5_async_valid", {63'd0, ifc.out_valid}, 64'd0);
    for (int i = 0; i < 25; i++) chk("s5_async_od", 64'(ifc.od[i]), 64'd0);
    @(posedge clock); #1;
    rst_n = 1;
    @(posedge clock); #1;
    clr(); frame(6, 0, 0, 0); idle(3);
    cmp_ref("s5_after_rst");

    px(1'b1, 1'b1, 16'($urandom));
    for (int i = 0; i < 600; i++) begin
      logic v;
      v = $urandom_range(0, 3) != 0;
      px(v, v && $urandom_range(0, 59) == 0, 16'($urandom));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
